uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 60 ++++++
 tb/tb_uart_tx_fifo.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through byte FIFO that feeds a UART transmitter
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [DATA_BITS-1:0]   in_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [DATA_BITS-1:0]   out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   afull,
    input  logic                   clr_err,
    output logic                   ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL = CW'(AFULL_LEVEL);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;

    // handshakes and status flags decoded from registered occupancy only
    always_comb begin
        in_rdy   = count < FULL;
        out_vld  = count != '0;
        empty    = count == '0;
        afull    = count >= AFULL;
        out_data = mem[rd_ptr];
        push     = in_vld && in_rdy;
        pop      = out_vld && out_rdy;
    end

    // byte storage, written only on an accepted push outside reset
    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= in_data;
    end

    // pointers, occupancy and sticky overflow flag (new overflow beats clear)
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count   <= count + CW'(push) - CW'(pop);
            ovf_err <= (in_vld && !in_rdy) || (ovf_err && !clr_err);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [7:0] in_data = 8'h00;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic [7:0] out_data;
    logic [4:0] count;
    logic       empty;
    logic       afull;
    logic       clr_err = 1'b0;
    logic       ovf_err;

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_fifo dut (
        .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .count(count),
        .empty(empty), .afull(afull), .clr_err(clr_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        step();
        step();
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld got %b want 0", out_vld); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_checks++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", afull); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single;
        in_vld = 1'b1; in_data = 8'hA5; out_rdy = 1'b0;
        step();
        in_vld = 1'b0;
        n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_out_vld got %b want 1", out_vld); end
        n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data got %h want a5", out_data); end
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", count); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b want 0", empty); end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty got %b want 1", empty); end
        in_vld = 1'b1; in_data = 8'h3C; out_rdy = 1'b1;
        #1;
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL empty_push_out_vld got %b want 0", out_vld); end
        step();
        in_vld = 1'b0;
        n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL empty_push_count got %0d want 1", count); end
        n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL empty_push_data got %h want 3c", out_data); end
        step();
        out_rdy = 1'b0;
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL empty_push_pop_count got %0d want 0", count); end
    endtask

    task automatic test_fill_drain;
        out_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_vld = 1'b1; in_data = 8'(i);
            step();
            n_checks++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            n_checks++; if (afull !== (i + 1 >= 12)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull, i + 1 >= 12); end
        end
        in_vld = 1'b0;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL full_in_rdy got %b want 0", in_rdy); end
        step();
        n_checks++; if (out_vld !== 1'b1 || out_data !== 8'h00) begin n_fail++; $display("FAIL hold_head got %b/%h want 1/00", out_vld, out_data); end
        in_vld = 1'b1; in_data = 8'hFF;
        step();
        in_vld = 1'b0;
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf_err); end
        n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", count); end
        in_vld = 1'b1; clr_err = 1'b1;
        step();
        in_vld = 1'b0;
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", ovf_err); end
        step();
        clr_err = 1'b0;
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", ovf_err); end
        out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (out_vld !== 1'b1 || out_data !== 8'(i)) begin n_fail++; $display("FAIL drain[%0d] got %b/%h want 1/%h", i, out_vld, out_data, 8'(i)); end
            step();
        end
        out_rdy = 1'b0;
        n_checks++; if (empty !== 1'b1 || out_vld !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b/%b want 1/0", empty, out_vld); end
    endtask

    task automatic test_full_pop_push;
        for (int i = 0; i < 16; i++) begin
            in_vld = 1'b1; in_data = 8'(8'h10 + i);
            step();
        end
        in_data = 8'h80; out_rdy = 1'b1;
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL fullpop_in_rdy got %b want 0", in_rdy); end
        step();
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL fullpop_c1_count got %0d want 15", count); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL fullpop_c1_in_rdy got %b want 1", in_rdy); end
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL fullpop_ovf got %b want 1", ovf_err); end
        step();
        in_vld = 1'b0; out_rdy = 1'b0; clr_err = 1'b1;
        n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL fullpop_c2_count got %0d want 15", count); end
        step();
        clr_err = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            n_checks++; if (out_data !== (i < 14 ? 8'(8'h12 + i) : 8'h80)) begin n_fail++; $display("FAIL fullpop_drain[%0d] got %h want %h", i, out_data, i < 14 ? 8'(8'h12 + i) : 8'h80); end
            step();
        end
        out_rdy = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullpop_empty got %b want 1", empty); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            in_vld = 1'b1; in_data = 8'(8'h40 + i);
            step();
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data = 8'(8'h45 + k);
            n_checks++; if (out_data !== 8'(8'h40 + k)) begin n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", k, out_data, 8'(8'h40 + k)); end
            step();
            n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d want 5", k, count); end
        end
        in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_data !== 8'(8'h68 + i)) begin n_fail++; $display("FAIL b2b_tail[%0d] got %h want %h", i, out_data, 8'(8'h68 + i)); end
            step();
        end
        out_rdy = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 7; i++) begin
            in_vld = 1'b1; in_data = 8'(8'h90 + i);
            step();
        end
        n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL mid_pre_count got %0d want 7", count); end
        reset = 1'b0; out_rdy = 1'b1; clr_err = 1'b1;
        step();
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_out_vld got %b want 0", out_vld); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_in_rdy got %b want 1", in_rdy); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL mid_ovf got %b want 0", ovf_err); end
        reset = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; clr_err = 1'b0;
        step();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_after_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pop_push();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
